restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 35 +++
 rtl/restoring_divider.sv | 144 ++++++++++++++
 tb/tb_restoring_divider.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the restoring divider:
//   DIV_WIDTH    - default operand / quotient / remainder width
//   div_state_e  - controller states (IDLE, CALC, DONE)
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration, MSB first.
// Ports:
//   i_rem  [WIDTH:0]   partial remainder before the step
//   i_quo  [WIDTH-1:0] quotient/dividend shift register before the step
//   i_div  [WIDTH-1:0] divisor
//   o_rem  [WIDTH:0]   partial remainder after the step
//   o_quo  [WIDTH-1:0] shift register after the step (new bit in LSB)
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_div_ext;
  logic           w_ge;

  // Shift {remainder, quotient} left by one; the dividend MSB enters the
  // remainder. The remainder MSB that falls out is still honoured in the
  // compare, so the step is correct even for an out-of-range input.
  assign w_shift   = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
  assign w_div_ext = {1'b0, i_div};
  assign w_ge      = i_rem[WIDTH] | (w_shift >= w_div_ext);

  assign o_rem = w_ge ? (w_shift - w_div_ext) : w_shift;
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/restoring_divider.sv
// -----------------------------------------------------------------------------
// restoring_divider
// Unsigned iterative restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both sides.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      operand handshake (ready only in IDLE)
//   dividend, divisor        unsigned operands, WIDTH bits
//   out_valid / out_ready    result handshake (valid only in DONE)
//   quotient, remainder      unsigned result, WIDTH bits
//   div_by_zero              result came from a zero divisor
// -----------------------------------------------------------------------------
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e       r_state;
  div_state_e       w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic             r_dbz;

  logic [WIDTH:0]   w_rem_step;
  logic [WIDTH-1:0] w_quo_step;
  logic             w_accept;
  logic             w_release;
  logic             w_zero_div;

  assign w_accept   = in_valid && in_ready;
  assign w_release  = out_valid && out_ready;
  assign w_zero_div = (divisor == '0);

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_divisor),
    .o_rem (w_rem_step),
    .o_quo (w_quo_step)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = w_zero_div ? DONE : CALC;
        end
      end
      CALC: begin
        // r_count holds the number of iterations already done, so this edge
        // performs iteration WIDTH when it equals WIDTH-1.
        if (r_count == LAST_ITER) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (w_release) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode, purely from the registered state
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_count   <= '0;
            r_divisor <= divisor;
            if (w_zero_div) begin
              // Divide-by-zero convention: all-ones quotient, dividend as remainder
              r_quo <= '1;
              r_rem <= {1'b0, dividend};
              r_dbz <= 1'b1;
            end else begin
              r_quo <= dividend;
              r_rem <= '0;
              r_dbz <= 1'b0;
            end
          end
        end
        CALC: begin
          r_rem   <= w_rem_step;
          r_quo   <= w_quo_step;
          r_count <= r_count + CNT_W'(1);
        end
        default: begin
          // DONE: result held until the consumer takes it
        end
      endcase
    end
  end

  assign quotient    = r_quo;
  assign remainder   = r_rem[WIDTH-1:0];
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

  localparam int W     = 8;
  localparam int N_RND = 1000;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: plain integer division, with the zero-divisor convention.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Present one operand pair, push its expected result, optionally measure the
  // number of edges after the accepting edge until out_valid is seen.
  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit chk_lat, input int exp_lat, input string tag);
    int g;
    int lat;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_val({tag, "_in_ready"}, in_ready, 1);
    if (in_ready) begin
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      sb_q.push_back(model(a, b));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (chk_lat) begin
        lat = 0;
        while (!out_valid && lat < 100) begin
          @(posedge clk);
          #1;
          lat++;
        end
        check_val({tag, "_latency"}, lat, exp_lat);
      end
    end
  endtask

  // Take one result: compare against the scoreboard, then complete the handshake.
  task automatic collect(input string tag);
    int   g;
    exp_t e;
    g = 0;
    out_ready = 1'b1;
    while (!out_valid && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_val({tag, "_out_valid"}, out_valid, 1);
    check_val({tag, "_sb_depth"}, sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val({tag, "_quotient"}, quotient, e.q);
      check_val({tag, "_remainder"}, remainder, e.r);
      check_val({tag, "_div_by_zero"}, div_by_zero, e.dz);
      $display("op %s: %0d / %0d -> q=%0d r=%0d dz=%0b", tag, e.a, e.b, quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
    check_val({tag, "_idle_in_ready"}, in_ready, 1);
    check_val({tag, "_idle_out_valid"}, out_valid, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_quotient", quotient, 0);
    check_val("rst_remainder", remainder, 0);
    check_val("rst_div_by_zero", div_by_zero, 0);
    rst = 1'b0;

    // Directed operations
    send_op(8'd200, 8'd7, 1'b1, W, "200div7");
    collect("200div7");
    send_op(8'd5, 8'd9, 1'b0, 0, "5div9");
    collect("5div9");
    send_op(8'd255, 8'd1, 1'b0, 0, "255div1");
    collect("255div1");
    send_op(8'd0, 8'd17, 1'b0, 0, "0div17");
    collect("0div17");
    // Zero divisor goes straight to DONE on the accepting edge itself.
    send_op(8'd13, 8'd0, 1'b1, 0, "13div0");
    collect("13div0");
    send_op(8'd10, 8'd3, 1'b0, 0, "10div3");
    collect("10div3");

    // Backpressure: 77 / 5 = 15 r 2 held while out_ready is low
    out_ready = 1'b0;
    send_op(8'd77, 8'd5, 1'b1, W, "bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 8'(k + 1);
      divisor  = 8'd1;
      check_val("bp_in_ready", in_ready, 0);
      check_val("bp_out_valid", out_valid, 1);
      check_val("bp_quotient", quotient, 15);
      check_val("bp_remainder", remainder, 2);
      check_val("bp_div_by_zero", div_by_zero, 0);
    end
    // in_valid stays high across the release edge and must not be taken there.
    dividend = 8'd9;
    divisor  = 8'd2;
    collect("bp");
    in_valid = 1'b0;

    // Reset in the middle of CALC (after iteration 4)
    send_op(8'd200, 8'd7, 1'b0, 0, "rst_mid");
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_in_ready", in_ready, 1);
    check_val("midrst_quotient", quotient, 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    send_op(8'd100, 8'd10, 1'b1, W, "100div10");
    collect("100div10");

    // Randomized back-to-back stream with random output backpressure
    fork
      begin : driver
        logic [W-1:0] a;
        logic [W-1:0] b;
        int g;
        for (int i = 0; i < N_RND; i++) begin
          a = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(0, 3));
          case ($urandom_range(0, 9))
            0:       b = 8'd0;
            1, 2, 3: b = 8'($urandom_range(1, 15));
            default: b = 8'($urandom_range(1, 255));
          endcase
          @(negedge clk);
          dividend = a;
          divisor  = b;
          in_valid = 1'b1;
          g = 0;
          while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
          end
          if (!in_ready) begin
            check_val("rnd_accept_timeout", in_ready, 1);
            break;
          end
          sb_q.push_back(model(a, b));
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin : monitor
        int   got;
        int   g;
        exp_t e;
        got = 0;
        g   = 0;
        while (got < N_RND && g < 60000) begin
          @(negedge clk);
          g++;
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            check_val("rnd_sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
              e = sb_q.pop_front();
              check_val("rnd_quotient", quotient, e.q);
              check_val("rnd_remainder", remainder, e.r);
              check_val("rnd_div_by_zero", div_by_zero, e.dz);
              if (e.b != 0) begin
                check_val("rnd_identity",
                          ((int'(quotient) * int'(e.b) + int'(remainder)) == int'(e.a)) &&
                          (remainder < e.b), 1);
              end
              $display("op rnd%0d: %0d / %0d -> q=%0d r=%0d dz=%0b", got, e.a, e.b, quotient, remainder, div_by_zero);
            end
            got++;
          end
        end
        check_val("rnd_results_received", got, N_RND);
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
